// File: rtl/btn_pkg.sv
// Shared types and clock-derived defaults for the button conditioner.
// Defaults assume a 25.125 MHz pixel clock.
package btn_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    localparam int CLK_HZ            = 25_125_000;
    localparam int DEF_CNT_MAX       = CLK_HZ / 100;
    localparam int DEF_REPEAT_DELAY  = CLK_HZ / 2;
    localparam int DEF_REPEAT_PERIOD = CLK_HZ / 10;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Bundle of button pins, repeat enables and conditioned outputs.
// master drives raw buttons, slave is the conditioner.
interface btn_conditioner_if #(
    parameter int N_CH = 3
) ();

    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] repeat_en;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_press;
    logic [N_CH-1:0] btn_release;
    logic [N_CH-1:0] btn_held;

    modport master (
        output btn_in,
        output repeat_en,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_held
    );

    modport slave (
        input  btn_in,
        input  repeat_en,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_held
    );

endinterface

// File: rtl/btn_channel.sv
// One button channel: synchroniser, stable-count debouncer,
// press/release pulses and hold-to-repeat generator.
module btn_channel
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_MAX       = DEF_CNT_MAX,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_held
);

    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int TW = $clog2(max_of(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CW-1:0]          cnt;
    logic                   accept;
    logic                   rise;
    logic                   fall;
    rpt_state_t             state;
    logic [TW-1:0]          timer;

    assign s      = sync[SYNC_STAGES-1];
    assign accept = (s != btn_level) && (cnt == CW'(CNT_MAX - 1));
    assign rise   = accept & s;
    assign fall   = accept & ~s;

    // Bring the raw pin into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_in};
        end
    end

    // Accept a new level only after CNT_MAX consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            btn_level <= 1'b0;
        end else if (s == btn_level) begin
            cnt <= '0;
        end else if (accept) begin
            cnt       <= '0;
            btn_level <= s;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Edge pulses and hold-to-repeat; a release always wins over a repeat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RPT_IDLE;
            timer       <= '0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_held    <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            if (fall) begin
                state       <= RPT_IDLE;
                timer       <= '0;
                btn_release <= 1'b1;
                btn_held    <= 1'b0;
            end else begin
                case (state)
                    RPT_IDLE: begin
                        if (rise) begin
                            state     <= RPT_DELAY;
                            timer     <= TW'(1);
                            btn_press <= 1'b1;
                        end
                    end
                    RPT_DELAY: begin
                        if (timer == TW'(REPEAT_DELAY)) begin
                            if (repeat_en) begin
                                state     <= RPT_REPEAT;
                                timer     <= TW'(1);
                                btn_press <= 1'b1;
                                btn_held  <= 1'b1;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    RPT_REPEAT: begin
                        if (timer == TW'(REPEAT_PERIOD)) begin
                            timer     <= TW'(1);
                            btn_press <= repeat_en;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: begin
                        state    <= RPT_IDLE;
                        timer    <= '0;
                        btn_held <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// N-channel button front end for the pixel-clock domain.
// Each bit of the bus is handled by an independent btn_channel.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_CH          = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_MAX       = DEF_CNT_MAX,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic              clk,
    input  logic              reset,
    btn_conditioner_if.slave  bus
);

    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] rel;
    logic [N_CH-1:0] held;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .CNT_MAX      (CNT_MAX),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .btn_in     (bus.btn_in[i]),
            .repeat_en  (bus.repeat_en[i]),
            .btn_level  (level[i]),
            .btn_press  (press[i]),
            .btn_release(rel[i]),
            .btn_held   (held[i])
        );
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = rel;
    assign bus.btn_held    = held;

endmodule
